// File: rtl/smac_pkg.sv
// smac_pkg: shared FSM state type and width helpers for the shift-accumulate block
package smac_pkg;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    function automatic int in_w(input int m, input int pa);
        return $clog2(m) + pa + 1;
    endfunction

    function automatic int acc_w(input int m, input int pa, input int pw);
        return $clog2(m) + pa + pw;
    endfunction

endpackage

// File: rtl/shift_acc_block_if.sv
// shift_acc_block_if: bit-plane input and accumulated result signals
interface shift_acc_block_if import smac_pkg::*; #(
    parameter int M  = 16,
    parameter int Pa = 8,
    parameter int Pw = 8
) ();
    localparam int IN_W  = in_w(M, Pa);
    localparam int ACC_W = acc_w(M, Pa, Pw);

    logic             start;
    logic             in_valid;
    logic [IN_W-1:0]  in_acc;
    logic [ACC_W-1:0] out_acc;
    logic             out_valid;
    logic             busy;

    modport master (output start, in_valid, in_acc, input out_acc, out_valid, busy);
    modport slave  (input start, in_valid, in_acc, output out_acc, out_valid, busy);
endinterface

// File: rtl/plane_counter.sv
// plane_counter: counts consumed bit-planes and flags the last one of a job
module plane_counter #(
    parameter int Pw = 8,
    parameter int CW = $clog2(Pw + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);
    assign last = cnt == CW'(Pw - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= clr ? '0 : en ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/shift_acc_block.sv
// shift_acc_block: MSB-first shift-and-add of signed bit-plane partial sums
module shift_acc_block import smac_pkg::*; #(
    parameter int M  = 16,
    parameter int Pa = 8,
    parameter int Pw = 8
) (
    input logic             clk,
    input logic             rst_n,
    shift_acc_block_if.slave bus
);
    localparam int ACC_W = acc_w(M, Pa, Pw);
    localparam int CW    = $clog2(Pw + 1);

    state_t           state;
    logic [ACC_W-1:0] acc, ext, nxt;
    logic [CW-1:0]    cnt;
    logic             last, take;

    assign take = state == ACC && bus.in_valid;
    assign ext  = ACC_W'($signed(bus.in_acc));
    // First plane of a job loads rather than shifts, so stale acc never leaks in
    assign nxt  = cnt == '0 ? ext : (acc << 1) + ext;

    plane_counter #(.Pw(Pw)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (state != ACC),
        .en   (take),
        .cnt  (cnt),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            bus.out_acc   <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    state    <= ACC;
                    bus.busy <= 1'b1;
                end
                ACC: if (take) begin
                    acc <= nxt;
                    if (last) begin
                        state         <= DONE;
                        bus.out_acc   <= nxt;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                DONE: begin
                    bus.out_valid <= 1'b0;
                    state         <= bus.start ? ACC : IDLE;
                    bus.busy      <= bus.start;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/shift_acc_block.md
SHIFT_ACC_BLOCK -- requirements
Module: shift_acc_block

Interface
REQ-001 SHALL have parameter M, default 16, meaning number of activations summed per bit-plane (matches the upstream negation stage).
REQ-002 SHALL have parameter Pa, default 8, meaning activation precision in bits.
REQ-003 SHALL have parameter Pw, default 8, meaning weight precision, i.e. bit-planes per MAC result; legal range 1..32.
REQ-004 SHALL derive IN_W = $clog2(M)+Pa+1 and ACC_W = $clog2(M)+Pa+Pw.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  request to begin a new Pw-plane accumulation.
REQ-008 in_valid  input  1  in_acc carries a valid bit-plane partial sum this cycle.
REQ-009 in_acc  input  IN_W  signed bit-plane partial sum from the negation stage, already negated for the weight MSB plane.
REQ-010 out_acc  output  ACC_W  signed accumulated MAC result, registered.
REQ-011 out_valid  output  1  one-cycle pulse marking a new out_acc value.
REQ-012 busy  output  1  high while in state ACC.

Function
REQ-013 SHALL implement FSM states IDLE, ACC, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> ACC, plane counter cleared to 0; in_valid ignored.
REQ-015 ACC: each cycle with in_valid=1 consumes one plane; in_valid=0 holds all state (stall, no timeout).
REQ-016 Planes arrive MSB-first; first consumed plane (counter=0) SHALL load acc <= sign-extend(in_acc) to ACC_W.
REQ-017 Each later consumed plane SHALL update acc <= (acc << 1) + sign-extend(in_acc), arithmetic modulo 2^ACC_W, two's-complement wrap, no saturation.
REQ-018 Counter SHALL increment per consumed plane; the cycle consuming plane Pw-1 SHALL transition ACC -> DONE.
REQ-019 On entry to DONE, out_acc SHALL hold the final acc and out_valid SHALL be 1 for exactly that one cycle; latency = 1 cycle after the last valid plane.
REQ-020 DONE: start=1 -> ACC (back-to-back job, counter cleared); else -> IDLE.
REQ-021 start while in ACC SHALL be ignored; the current job is not disturbed.
REQ-022 start and in_valid together in IDLE/DONE: only start acts; that in_acc is not consumed.
REQ-023 out_acc SHALL hold its last value until the next DONE; it is not cleared by a new start.
REQ-024 Pw=1: the single plane loads acc and goes directly to DONE.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, counter 0, acc 0, out_acc 0, out_valid 0, busy 0.
REQ-026 Reset asserted mid-job SHALL discard the partial result; no out_valid follows reset release.
REQ-027 After rst_n release, the first start SHALL be honoured on the first rising edge.

Structure
REQ-028 State enum (IDLE/ACC/DONE) and the ACC_W width helper SHALL live in shared package smac_pkg.
REQ-029 Plane counter SHALL be a sub-module plane_counter (width $clog2(Pw+1), clear, enable, last flag); datapath and FSM remain in shift_acc_block.

Verification (bench: M=16, Pa=8, Pw=4, IN_W=13, ACC_W=16)
REQ-030 start, then planes -3,1,0,2 on consecutive in_valid cycles -> out_acc=-18, out_valid one pulse one cycle after last plane, busy high for exactly 4 cycles.
REQ-031 Same planes with in_valid=0 gaps of 1 and 3 cycles between planes -> out_acc=-18, single out_valid pulse, no plane consumed during gaps.
REQ-032 Planes -4096,-4096,-4096,-4096 -> out_acc=-61440 mod 2^16 = 4096 (wrap, not saturate).
REQ-033 Back-to-back: start asserted in DONE cycle, second job planes 1,1,1,1 -> first result -18, second result 15, no IDLE cycle between jobs.
REQ-034 start pulsed during plane 2 of a job -> ignored, out_acc=-18 for planes -3,1,0,2.
REQ-035 rst_n low after plane 2 of a job -> all outputs 0 immediately, no out_valid after release; fresh job with planes 0,0,0,5 -> out_acc=5.
